// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// SCK comes from a registered divider so a slave that edge-detects it sees clean transitions.
module spi_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data
);

  localparam int unsigned DivW = $clog2(CLK_DIV + 1);
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;

  // One SCK half-period has elapsed when the divider reaches CLK_DIV-1.
  assign tick = (div_q == DivW'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = tx_data[DATA_WIDTH-1];
          tx_sh_d = tx_data;
          div_d   = '0;
          cnt_d   = '0;
          state_d = StLead;
        end
      end
      StLead: begin
        if (tick) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
          state_d = StXfer;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StXfer: begin
        if (tick) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
          end else begin
            sclk_d = 1'b0;
            // The last falling edge leaves mosi on the final bit.
            if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
              state_d = StTrail;
            end else begin
              cnt_d   = cnt_q + CntW'(1);
              tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
              mosi_d  = tx_sh_q[DATA_WIDTH-2];
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StTrail: begin
        if (tick) begin
          div_d     = '0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          state_d   = StIdle;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      cnt_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) checked against
// edge-count timing and bit-order expectations derived from the transfer rules.
module tb_spi_master;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic start0 = 1'b0, start1 = 1'b0;
  logic [W-1:0] tx0 = '0, tx1 = '0;
  logic loop0 = 1'b1, loop1 = 1'b1;
  logic miso_drv0 = 1'b0, miso_drv1 = 1'b0;
  logic miso0, miso1;
  logic sclk0, cs_n0, mosi0, busy0, done0;
  logic sclk1, cs_n1, mosi1, busy1, done1;
  logic [W-1:0] rx0, rx1;

  assign miso0 = loop0 ? mosi0 : miso_drv0;
  assign miso1 = loop1 ? mosi1 : miso_drv1;

  spi_master #(.DATA_WIDTH(W), .CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .tx_data(tx0), .miso(miso0),
    .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .busy(busy0), .done(done0), .rx_data(rx0)
  );

  spi_master #(.DATA_WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx1), .miso(miso1),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .busy(busy1), .done(done1), .rx_data(rx1)
  );

  int checks = 0;
  int passes = 0;

  // Observations of the most recent transfer, counted in clk edges after the accepting edge.
  int r_done_edge, r_done_cnt, r_rises, r_falls, r_cs_low, r_sclk_idle, r_mosi_hi;
  logic r_busy_at_done, r_cs_at_done, r_cs_first;
  logic [W-1:0] r_rx, r_mosi_seq;
  int rise_e[W];
  int fall_e[W];

  task automatic run(input int sel, input logic [W-1:0] tx, input bit loop,
                     input logic [W-1:0] mword, input int inj_edge, input logic [W-1:0] inj_tx,
                     input bit keep_start, input int tail);
    logic s, c, m, d, b, prev;
    logic [W-1:0] rxv;
    if (sel == 0) begin
      loop0 = loop; miso_drv0 = mword[W-1]; start0 = 1'b1; tx0 = tx;
    end else begin
      loop1 = loop; miso_drv1 = mword[W-1]; start1 = 1'b1; tx1 = tx;
    end
    r_done_edge = -1; r_done_cnt = 0; r_rises = 0; r_falls = 0; r_cs_low = 0;
    r_sclk_idle = 0; r_mosi_hi = 0; r_mosi_seq = '0; r_rx = '0;
    r_busy_at_done = 1'bx; r_cs_at_done = 1'bx; r_cs_first = 1'bx;
    for (int k = 0; k < W; k++) begin rise_e[k] = -1; fall_e[k] = -1; end
    prev = 1'b0;
    @(posedge clk); #1;
    for (int e = 0; e <= 200; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (e == 0) begin
        if (sel == 0) begin tx0 = ~tx; if (!keep_start) start0 = 1'b0; end
        else begin tx1 = ~tx; if (!keep_start) start1 = 1'b0; end
      end
      if (e == inj_edge) begin
        if (sel == 0) begin start0 = 1'b1; tx0 = inj_tx; end
        else begin start1 = 1'b1; tx1 = inj_tx; end
      end
      if (e == inj_edge + 1) begin
        if (sel == 0) start0 = 1'b0; else start1 = 1'b0;
      end
      s = sel ? sclk1 : sclk0;  c = sel ? cs_n1 : cs_n0;  m = sel ? mosi1 : mosi0;
      d = sel ? done1 : done0;  b = sel ? busy1 : busy0;  rxv = sel ? rx1 : rx0;
      if (e == 0) r_cs_first = c;
      if (!c) r_cs_low++;
      if (c && s) r_sclk_idle++;
      if (!c && m) r_mosi_hi++;
      if (s && !prev) begin
        if (r_rises < W) begin
          rise_e[r_rises] = e;
          r_mosi_seq[W-1-r_rises] = m;
        end
        r_rises++;
        if (!loop && r_rises < W) begin
          if (sel == 0) miso_drv0 = mword[W-1-r_rises]; else miso_drv1 = mword[W-1-r_rises];
        end
      end
      if (!s && prev) begin
        if (r_falls < W) fall_e[r_falls] = e;
        r_falls++;
      end
      prev = s;
      if (d) begin
        r_done_cnt++;
        if (r_done_cnt == 1) begin
          r_done_edge = e; r_busy_at_done = b; r_cs_at_done = c; r_rx = rxv;
        end
      end
      if (r_done_edge >= 0 && e >= r_done_edge + tail) break;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (sclk0 !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk0); else passes++;
    checks++; if (cs_n0 !== 1'b1) $display("FAIL reset_cs_n got %b want 1", cs_n0); else passes++;
    checks++; if (mosi0 !== 1'b0) $display("FAIL reset_mosi got %b want 0", mosi0); else passes++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else passes++;
    checks++; if (done0 !== 1'b0) $display("FAIL reset_done got %b want 0", done0); else passes++;
    checks++; if (rx0 !== '0) $display("FAIL reset_rx got %h want 00", rx0); else passes++;
    checks++; if (cs_n1 !== 1'b1) $display("FAIL reset_cs_n_div1 got %b want 1", cs_n1); else passes++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback();
    run(0, 8'hA5, 1'b1, 8'h00, -1, 8'h00, 1'b0, 3);
    checks++; if (r_done_edge != 34) $display("FAIL lb_done_edge got %0d want 34", r_done_edge); else passes++;
    checks++; if (r_rx !== 8'hA5) $display("FAIL lb_rx got %h want a5", r_rx); else passes++;
    checks++; if (r_mosi_seq !== 8'hA5) $display("FAIL lb_mosi_seq got %h want a5", r_mosi_seq); else passes++;
    checks++; if (r_rises != W) $display("FAIL lb_rises got %0d want %0d", r_rises, W); else passes++;
    checks++; if (r_falls != W) $display("FAIL lb_falls got %0d want %0d", r_falls, W); else passes++;
    checks++; if (r_done_cnt != 1) $display("FAIL lb_done_cnt got %0d want 1", r_done_cnt); else passes++;
    checks++; if (r_busy_at_done !== 1'b0) $display("FAIL lb_busy_at_done got %b want 0", r_busy_at_done); else passes++;
    checks++; if (r_cs_at_done !== 1'b1) $display("FAIL lb_cs_at_done got %b want 1", r_cs_at_done); else passes++;
    checks++; if (r_sclk_idle != 0) $display("FAIL lb_sclk_idle got %0d want 0", r_sclk_idle); else passes++;
    for (int k = 0; k < W; k++) begin
      checks++;
      if (rise_e[k] != 2 * (2 * k + 1)) $display("FAIL lb_rise%0d got %0d want %0d", k + 1, rise_e[k], 2 * (2 * k + 1));
      else passes++;
      checks++;
      if (fall_e[k] != 2 * (2 * k + 2)) $display("FAIL lb_fall%0d got %0d want %0d", k + 1, fall_e[k], 2 * (2 * k + 2));
      else passes++;
    end
    checks++; if (rx0 !== 8'hA5) $display("FAIL lb_rx_hold got %h want a5", rx0); else passes++;
  endtask

  task automatic test_miso_high();
    run(0, 8'h00, 1'b0, 8'hFF, -1, 8'h00, 1'b0, 2);
    checks++; if (r_rx !== 8'hFF) $display("FAIL mh_rx got %h want ff", r_rx); else passes++;
    checks++; if (r_mosi_hi != 0) $display("FAIL mh_mosi_hi got %0d want 0", r_mosi_hi); else passes++;
    checks++; if (r_cs_low != 34) $display("FAIL mh_cs_low got %0d want 34", r_cs_low); else passes++;
  endtask

  task automatic test_ignore_start();
    run(0, 8'hA5, 1'b1, 8'h00, 10, 8'h3C, 1'b0, 4);
    checks++; if (r_rx !== 8'hA5) $display("FAIL ig_rx got %h want a5", r_rx); else passes++;
    checks++; if (r_done_cnt != 1) $display("FAIL ig_done_cnt got %0d want 1", r_done_cnt); else passes++;
    checks++; if (r_done_edge != 34) $display("FAIL ig_done_edge got %0d want 34", r_done_edge); else passes++;
    checks++; if (rise_e[7] != 30) $display("FAIL ig_rise8 got %0d want 30", rise_e[7]); else passes++;
    checks++; if (busy0 !== 1'b0) $display("FAIL ig_idle_after got %b want 0", busy0); else passes++;
  endtask

  task automatic test_back_to_back();
    int first_done;
    run(0, 8'h12, 1'b1, 8'h00, -1, 8'h00, 1'b1, 0);
    first_done = r_done_edge;
    checks++; if (first_done != 34) $display("FAIL b2b_done1 got %0d want 34", first_done); else passes++;
    checks++; if (r_rx !== 8'h12) $display("FAIL b2b_rx1 got %h want 12", r_rx); else passes++;
    checks++; if (r_cs_at_done !== 1'b1) $display("FAIL b2b_cs_gap got %b want 1", r_cs_at_done); else passes++;
    run(0, 8'h34, 1'b1, 8'h00, -1, 8'h00, 1'b0, 3);
    checks++; if (r_cs_first !== 1'b0) $display("FAIL b2b_cs_relow got %b want 0", r_cs_first); else passes++;
    checks++;
    if (first_done + 1 + r_done_edge != 69) $display("FAIL b2b_done2 got %0d want 69", first_done + 1 + r_done_edge);
    else passes++;
    checks++; if (r_rx !== 8'h34) $display("FAIL b2b_rx2 got %h want 34", r_rx); else passes++;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    loop0 = 1'b1; start0 = 1'b1; tx0 = 8'hA5;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (sclk0 !== 1'b0) $display("FAIL rm_sclk got %b want 0", sclk0); else passes++;
    checks++; if (cs_n0 !== 1'b1) $display("FAIL rm_cs_n got %b want 1", cs_n0); else passes++;
    checks++; if (busy0 !== 1'b0) $display("FAIL rm_busy got %b want 0", busy0); else passes++;
    checks++; if (rx0 !== '0) $display("FAIL rm_rx got %h want 00", rx0); else passes++;
    checks++; if (mosi0 !== 1'b0) $display("FAIL rm_mosi got %b want 0", mosi0); else passes++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done0) dones++;
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done0) dones++;
    end
    checks++; if (dones != 0) $display("FAIL rm_no_done got %0d want 0", dones); else passes++;
    run(0, 8'h5A, 1'b1, 8'h00, -1, 8'h00, 1'b0, 2);
    checks++; if (r_done_edge != 34) $display("FAIL rm_fresh_done got %0d want 34", r_done_edge); else passes++;
    checks++; if (r_rx !== 8'h5A) $display("FAIL rm_fresh_rx got %h want 5a", r_rx); else passes++;
  endtask

  task automatic test_div1();
    run(1, 8'hC3, 1'b1, 8'h00, -1, 8'h00, 1'b0, 2);
    checks++; if (r_done_edge != 17) $display("FAIL d1_done_edge got %0d want 17", r_done_edge); else passes++;
    checks++; if (r_rx !== 8'hC3) $display("FAIL d1_rx got %h want c3", r_rx); else passes++;
    checks++; if (r_rises != W) $display("FAIL d1_rises got %0d want %0d", r_rises, W); else passes++;
    for (int k = 0; k < W; k++) begin
      checks++;
      if (rise_e[k] != 2 * k + 1) $display("FAIL d1_rise%0d got %0d want %0d", k + 1, rise_e[k], 2 * k + 1);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] tx, mw;
    int div;
    for (int i = 0; i < 8; i++) begin
      tx  = W'($urandom);
      mw  = W'($urandom);
      div = (i % 2 == 0) ? 2 : 1;
      run(i % 2, tx, 1'b0, mw, -1, 8'h00, 1'b0, 1);
      checks++; if (r_rx !== mw) $display("FAIL rnd%0d_rx got %h want %h", i, r_rx, mw); else passes++;
      checks++;
      if (r_mosi_seq !== tx) $display("FAIL rnd%0d_mosi got %h want %h", i, r_mosi_seq, tx);
      else passes++;
      checks++;
      if (r_done_edge != div * (2 * W + 1)) $display("FAIL rnd%0d_done got %0d want %0d", i, r_done_edge, div * (2 * W + 1));
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_high();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
